clock_set_ctrl: RTL
===================

# clock_set_ctrl

Mode and timebase controller for the digital clock. It sequences the three BCD time counters: hours (the 0–23 counter), minutes and seconds (0–59 counters). It generates the 1 Hz count enable and the carry-chained enables, runs a four-state run/set mode machine driven by two debounced keys, and drives each counter's `set_time`/`set` inputs plus a display blink signal. It sits between the key debouncers and the counter bank.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per second; must be ≥ 4 and even.
- `REPEAT_DLY`, default 25_000_000: hold cycles before the first auto-repeat (auto-repeat build only).
- `REPEAT_PER`, default 6_250_000: cycles between auto-repeats (auto-repeat build only).

Ports:
- `clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `key_mode`  in  1  debounced mode key, level, active-high.
- `key_inc`  in  1  debounced increment key, level, active-high.
- `sec_max`  in  1  seconds counter is at 59.
- `min_max`  in  1  minutes counter is at 59.
- `mode`  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- `tick`  out  1  one-cycle 1 Hz pulse; RUN state only.
- `sec_ena`, `min_ena`, `hour_ena`  out  1 each  count enables to the counters.
- `sec_set_time`, `min_set_time`, `hour_set_time`  out  1 each  set-mode level, one per counter.
- `set_pulse`  out  1  one-cycle increment strobe, fanned out to every counter's `set` input.
- `blink`  out  1  1 = the display shows the selected field.

## Operation
- State machine, encoded on `mode`: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. The state advances on each rising edge of `key_mode`.
- Edge detection: one previous-level register per key, reset to 1. A key still held when reset is released therefore produces no edge.
- Prescaler `pre`, width $clog2(TICK_DIV):
  - counts 0..TICK_DIV-1 and wraps;
  - clears to 0 on every state transition.
- `tick` is registered and is 1 for the cycle after `pre` reaches TICK_DIV-1, only while in RUN.
- Count enables (combinational from `tick` and the inputs):
  - `sec_ena = tick`
  - `min_ena = tick & sec_max`
  - `hour_ena = tick & sec_max & min_max`
  - All three are forced to 0 outside RUN.
- Set-mode levels: `hour_set_time`, `min_set_time`, `sec_set_time` are 1 exactly in SET_HOUR, SET_MIN, SET_SEC respectively. At most one is high at a time; all are low in RUN.
- `set_pulse` is registered and is 1 for one cycle after a `key_inc` rising edge in any SET state.
  - `key_inc` edges in RUN are ignored.
  - If `key_mode` and `key_inc` edges arrive in the same cycle, the mode change wins and the increment is dropped.
- `blink` is 1 in RUN. In a SET state it is 1 while `pre` < TICK_DIV/2, else 0 (1 Hz, 50 % duty).
- Field wrap (23→00, 59→00) is owned by the counters; this block never inspects counter values beyond `sec_max` and `min_max`.

## Timing
- Reset values, all outputs: `mode`=0 (RUN), `tick`=0, every enable 0, every `set_time` 0, `set_pulse`=0, `blink`=1. `pre`=0.
- Reset applies on the clk edge that samples `sys_rst_n`=0. A reset mid-set returns to RUN and drops any pending pulse.
- Key edge to `mode` change: 1 cycle after the edge is sampled.
- Key edge to `set_pulse`: 1 cycle after the edge is sampled.
- After reset, or after entering RUN, the first `tick` asserts TICK_DIV cycles later. Subsequent ticks are exactly TICK_DIV cycles apart.
- `set_pulse` never coincides with any `*_ena`, because set pulses occur only in SET states and enables only in RUN.

## Configuration
- Macro `CLOCK_SET_AUTO_REPEAT_EN`.
- Defined: in a SET state, if `key_inc` stays high for REPEAT_DLY cycles after its rising edge, a `set_pulse` is issued. Further pulses follow every REPEAT_PER cycles while the key is held. The repeat counter clears on key release, state change or reset.
- Undefined: only rising edges of `key_inc` generate `set_pulse`. The REPEAT_* parameters are unused and no repeat counter is synthesised.

## Structure
- Package `clock_ctrl_pkg`:
  - state enum typedef (RUN, SET_HOUR, SET_MIN, SET_SEC; 2-bit);
  - encoding localparams used by the display mux.
- Sub-module `key_edge`: a single-key rising-edge detector with reset-to-1 history. It is instantiated twice.

## Test plan
Use TICK_DIV=10, REPEAT_DLY=6, REPEAT_PER=3.
- Release reset and hold 35 cycles in RUN → `tick` high at cycles 10, 20, 30; `mode`=0 throughout; `blink`=1.
- Drive `sec_max`=1 and `min_max`=1 at a tick → `sec_ena`, `min_ena`, `hour_ena` all high that cycle. With `min_max`=0 → `hour_ena` stays low.
- Apply four `key_mode` presses → `mode` steps 1, 2, 3, 0, with the matching `*_set_time` high. No `tick` occurs while in a SET state. The first tick after returning to RUN comes 10 cycles later.
- In SET_MIN, press `key_inc` 3 times → 3 `set_pulse` cycles with `min_set_time`=1. Pressing `key_inc` in RUN → no pulse.
- Apply `key_mode` and `key_inc` edges in the same cycle in SET_HOUR → `mode`=2 and no `set_pulse`. Hold both keys through a reset release → no edges.
- With `CLOCK_SET_AUTO_REPEAT_EN`, hold `key_inc` for 15 cycles → pulses 1 cycle after the edge, then 6 cycles after it, then every 3 cycles. Assert reset mid-hold → `mode`=0 and pulses stop.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types for the digital-clock mode controller.
// State enum for the run/set machine plus the raw mode encodings the display
// mux decodes from the 2-bit mode output.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    // Mode key cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
    function automatic state_e next_mode(input state_e s);
        case (s)
            ST_RUN:      return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_MIN;
            ST_SET_MIN:  return ST_SET_SEC;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_edge.sv
// Single-key rising-edge detector (module key_edge).
// History resets to 1 so a key already held when reset releases gives no edge.
module key_edge (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic i_key,
    output logic o_rise
);

    logic r_prev;

    // Previous key level, reset high.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) r_prev <= 1'b1;
        else            r_prev <= i_key;
    end

    assign o_rise = i_key & ~r_prev;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and timebase controller for the BCD digital clock.
// Generates the 1 Hz tick and carry-chained count enables in RUN, and the
// set-mode levels, increment strobe and blink in the three SET states.
// Optional feature: define CLOCK_SET_AUTO_REPEAT_EN for held-key auto-repeat
// of the increment strobe (REPEAT_DLY first delay, REPEAT_PER period).
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 6_250_000
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic [1:0] mode,
    output logic       tick,
    output logic       sec_ena,
    output logic       min_ena,
    output logic       hour_ena,
    output logic       sec_set_time,
    output logic       min_set_time,
    output logic       hour_set_time,
    output logic       set_pulse,
    output logic       blink
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

    // Reject configurations the prescaler and repeat logic cannot honour.
    if (TICK_DIV < 4 || (TICK_DIV % 2) != 0 || REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY) begin : g_bad_params
        $error("clock_set_ctrl: illegal TICK_DIV/REPEAT_* parameters");
    end

    state_e        r_state;
    state_e        w_next_state;
    logic [PW-1:0] r_pre;
    logic          r_tick;
    logic          r_set_pulse;
    logic          w_mode_rise;
    logic          w_inc_rise;
    logic          w_run;
    logic          w_in_set;
    logic          w_inc_req;
    logic          w_pulse_req;

    key_edge u_mode_edge (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_key     (key_mode),
        .o_rise    (w_mode_rise)
    );

    key_edge u_inc_edge (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_key     (key_inc),
        .o_rise    (w_inc_rise)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) r_state <= ST_RUN;
        else            r_state <= w_next_state;
    end

    // Next state and per-state output levels.
    always_comb begin
        w_next_state  = r_state;
        w_run         = 1'b0;
        hour_set_time = 1'b0;
        min_set_time  = 1'b0;
        sec_set_time  = 1'b0;
        if (w_mode_rise) w_next_state = next_mode(r_state);
        case (r_state)
            MODE_RUN:      w_run         = 1'b1;
            MODE_SET_HOUR: hour_set_time = 1'b1;
            MODE_SET_MIN:  min_set_time  = 1'b1;
            MODE_SET_SEC:  sec_set_time  = 1'b1;
            default:       w_run         = 1'b1;
        endcase
    end

    assign w_in_set = ~w_run;
    // A mode edge in the same cycle wins; the increment is dropped.
    assign w_inc_req = w_inc_rise & w_in_set & ~w_mode_rise;

    // Prescaler: free-running modulo TICK_DIV, restarted on every state change.
    always_ff @(posedge clk) begin
        if (!sys_rst_n)           r_pre <= '0;
        else if (w_mode_rise)     r_pre <= '0;
        else if (r_pre == PRE_MAX) r_pre <= '0;
        else                      r_pre <= r_pre + 1'b1;
    end

    // 1 Hz tick, only while staying in RUN.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) r_tick <= 1'b0;
        else            r_tick <= w_run & ~w_mode_rise & (r_pre == PRE_MAX);
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int            RW         = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_PER + 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          w_rpt_fire;

    // Non-zero count = cycles the key has been held since its accepted edge.
    assign w_rpt_fire = (r_rpt_cnt == RPT_FIRE) & key_inc & w_in_set & ~w_mode_rise;

    // Hold counter: armed by an accepted edge, cleared by release/state change.
    always_ff @(posedge clk) begin
        if (!sys_rst_n || w_mode_rise || !key_inc || w_run) r_rpt_cnt <= '0;
        else if (w_inc_req)                                 r_rpt_cnt <= RW'(1);
        else if (w_rpt_fire)                                r_rpt_cnt <= RPT_RELOAD;
        else if (r_rpt_cnt != '0)                           r_rpt_cnt <= r_rpt_cnt + 1'b1;
    end

    assign w_pulse_req = w_inc_req | w_rpt_fire;
`else
    assign w_pulse_req = w_inc_req;
`endif

    // Registered one-cycle increment strobe.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) r_set_pulse <= 1'b0;
        else            r_set_pulse <= w_pulse_req;
    end

    assign mode      = r_state;
    assign tick      = r_tick;
    assign sec_ena   = r_tick & w_run;
    assign min_ena   = r_tick & w_run & sec_max;
    assign hour_ena  = r_tick & w_run & sec_max & min_max;
    assign set_pulse = r_set_pulse;
    assign blink     = w_run | (r_pre < PRE_HALF);

endmodule
